// File: rtl/spi_mmio_pkg.sv
// Shared types and register map for the memory-mapped SPI master.
package spi_mmio_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_RXVALID = 1;
  localparam int STAT_OVERRUN = 2;

endpackage

// File: rtl/spi_mmio_master_tick.sv
// Divider: one-cycle tick every div+1 cycles while enabled; reloads whenever idle.
module spi_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (!en || tick)
      cnt <= div;
    else
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/spi_mmio_master.sv
// Mode-0 MSB-first 8-bit SPI master with a DATA/STATUS/CLKDIV register window.
module spi_mmio_master
  import spi_mmio_pkg::*;
#(
  parameter int               DIV_W     = 8,
  parameter logic [DIV_W-1:0] DIV_RESET = 8'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_n
);

  state_t           state, state_n;
  logic [DIV_W-1:0] clkdiv, div_q, div_src;
  logic [7:0]       txsh, rxsh, rxbyte;
  logic [2:0]       bitcnt;
  logic             rx_valid, overrun, busy, tick, tick_en;
  logic             wr_data, wr_status, wr_div, rd_data, start, enter_high, last_bit;
  logic             unused_bits;

  assign unused_bits = ^{a[31:4], a[1:0], wd};

  assign wr_data   = cs && we && (a[3:2] == REG_DATA);
  assign wr_status = cs && we && (a[3:2] == REG_STATUS);
  assign wr_div    = cs && we && (a[3:2] == REG_CLKDIV);
  assign rd_data   = cs && re && (a[3:2] == REG_DATA);

  assign busy     = (state != IDLE);
  assign start    = wr_data && (state == IDLE);
  assign last_bit = (bitcnt == 3'd7);

  // Reload source follows CLKDIV while idle so the first SETUP phase already uses the latched divisor.
  assign div_src = (state == IDLE) ? clkdiv : div_q;
  assign tick_en = (state == SETUP) || (state == HIGH) || (state == LOW);

  spi_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .div   (div_src),
    .tick  (tick)
  );

  assign enter_high = tick && ((state == SETUP) || ((state == LOW) && !last_bit));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SETUP;
      SETUP:   if (tick)  state_n = HIGH;
      HIGH:    if (tick)  state_n = LOW;
      LOW:     if (tick)  state_n = last_bit ? DONE : HIGH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clkdiv   <= DIV_RESET;
      div_q    <= '0;
      txsh     <= '0;
      rxsh     <= '0;
      rxbyte   <= '0;
      bitcnt   <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_div) clkdiv <= wd[DIV_W-1:0];
      if (start) begin
        txsh   <= wd[7:0];
        div_q  <= clkdiv;
        bitcnt <= '0;
      end
      if (enter_high) rxsh <= {rxsh[6:0], miso};
      // mosi only moves on the falling edge, keeping data stable around each rising edge.
      if ((state == HIGH) && tick && !last_bit) txsh <= {txsh[6:0], 1'b0};
      if ((state == LOW) && tick && !last_bit) bitcnt <= bitcnt + 3'd1;
      if (state == DONE) begin
        rxbyte <= rxsh;
        txsh   <= '0;
      end

      if (state == DONE)  rx_valid <= 1'b1;
      else if (rd_data)   rx_valid <= 1'b0;

      if ((wr_data && busy) || ((state == DONE) && rx_valid))
        overrun <= 1'b1;
      else if (wr_status && wd[STAT_OVERRUN])
        overrun <= 1'b0;
    end
  end

  assign mosi = txsh[7];
  assign sclk = (state == HIGH);
  assign ss_n = (state == IDLE) || (state == DONE);

  always_comb begin
    rd = '0;
    case (a[3:2])
      REG_DATA:   rd[7:0] = rxbyte;
      REG_STATUS: begin
        rd[STAT_BUSY]    = busy;
        rd[STAT_RXVALID] = rx_valid;
        rd[STAT_OVERRUN] = overrun;
      end
      REG_CLKDIV: rd[DIV_W-1:0] = clkdiv;
      default:    rd = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_mmio_master.sv
// Scoreboard bench for spi_mmio_master: expected bytes queued at start, checked on completion.
module tb_spi_mmio_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, we = 1'b0, re = 1'b0;
  logic [31:0] a = 32'h4, wd = '0;
  logic [31:0] rd;
  logic        sclk, mosi, miso, ss_n;
  logic        loop = 1'b1, miso_tie = 1'b0;

  int checks = 0, failures = 0;
  int rises = 0;
  time rise_t[$];
  logic mosi_q[$];
  logic [7:0] sb[$];

  localparam logic [31:0] A_DATA = 32'h0, A_STATUS = 32'h4, A_DIV = 32'h8;

  assign miso = loop ? mosi : miso_tie;

  always #5 clk = ~clk;

  always @(posedge sclk) begin
    rises = rises + 1;
    rise_t.push_back($time);
    mosi_q.push_back(mosi);
  end

  spi_mmio_master dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .re(re), .a(a), .wd(wd),
    .rd(rd), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic c);
    @(negedge clk); cs = c; we = 1'b1; a = addr; wd = d;
    @(negedge clk); cs = 1'b0; we = 1'b0; a = A_STATUS; wd = '0;
  endtask

  task automatic rdreg(input logic [31:0] addr, input logic rev, output logic [31:0] v);
    @(negedge clk); cs = 1'b1; re = rev; a = addr;
    #1 v = rd;
    @(negedge clk); cs = 1'b0; re = 1'b0; a = A_STATUS;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    #1;
    while (rd[0] === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk); #1;
    end
    checks++;
    if (n >= 2000) begin failures++; $display("FAIL wait_idle timeout busy=%0d", n); end
  endtask

  task automatic check_pop(input string name, input logic [31:0] v);
    logic [7:0] e;
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL %s scoreboard empty got=%h", name, v);
    end else begin
      e = sb.pop_front();
      if (v !== {24'b0, e}) begin failures++; $display("FAIL %s got=%h exp=%h", name, v, e); end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    checks++; if (ss_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
      failures++; $display("FAIL reset_pins ss_n=%b sclk=%b mosi=%b exp 1/0/0", ss_n, sclk, mosi); end
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", v); end
    rdreg(A_DIV, 1'b0, v);
    checks++; if (v !== 32'h4) begin failures++; $display("FAIL reset_clkdiv got=%h exp=4", v); end
    rdreg(A_DATA, 1'b0, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", v); end
  endtask

  task automatic test_loopback_d0();
    logic [31:0] v;
    int n, base;
    loop = 1'b1;
    wr(A_DIV, 32'h0, 1'b1);
    base = rises;
    sb.push_back(8'hA5);
    wr(A_DATA, 32'hA5, 1'b1);
    wait_idle(n);
    checks++; if (n != 18) begin failures++; $display("FAIL d0_busy got=%0d exp=18", n); end
    checks++; if (rises - base != 8) begin failures++; $display("FAIL d0_rises got=%0d exp=8", rises - base); end
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL d0_status got=%h exp=2", v); end
    rdreg(A_DATA, 1'b1, v);
    check_pop("d0_data", v);
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL d0_rxv_clear got=%h exp=0", v); end
  endtask

  task automatic test_miso_high_d3();
    logic [31:0] v;
    logic [7:0] tx;
    int n, bq, bt;
    loop = 1'b0; miso_tie = 1'b1;
    tx = 8'h3C;
    wr(A_DIV, 32'h3, 1'b1);
    bq = mosi_q.size(); bt = rise_t.size();
    sb.push_back(8'hFF);
    wr(A_DATA, {24'b0, tx}, 1'b1);
    wait_idle(n);
    checks++; if (n != 69) begin failures++; $display("FAIL d3_busy got=%0d exp=69", n); end
    checks++; if (mosi_q.size() - bq != 8) begin
      failures++; $display("FAIL d3_rises got=%0d exp=8", mosi_q.size() - bq); end
    for (int i = 0; i < 8 && bq + i < mosi_q.size(); i++) begin
      checks++; if (mosi_q[bq+i] !== tx[7-i]) begin
        failures++; $display("FAIL d3_mosi bit%0d got=%b exp=%b", i, mosi_q[bq+i], tx[7-i]); end
    end
    for (int i = 1; i < 8 && bt + i < rise_t.size(); i++) begin
      checks++; if (rise_t[bt+i] - rise_t[bt+i-1] != 80) begin
        failures++; $display("FAIL d3_period got=%0t exp=80", rise_t[bt+i] - rise_t[bt+i-1]); end
    end
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL d3_status got=%h exp=2", v); end
    rdreg(A_DATA, 1'b1, v);
    check_pop("d3_data", v);
    loop = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int n;
    wr(A_DIV, 32'h0, 1'b1);
    sb.push_back(8'h11);
    wr(A_DATA, 32'h11, 1'b1);
    @(negedge clk);
    wr(A_DATA, 32'h22, 1'b1);
    wait_idle(n);
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h6) begin failures++; $display("FAIL b2b_status got=%h exp=6", v); end
    rdreg(A_DATA, 1'b1, v);
    check_pop("b2b_data", v);
    wr(A_STATUS, 32'h4, 1'b1);
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL b2b_ovr_clear got=%h exp=0", v); end
    // unread completion followed by another: overwrite plus overrun
    wr(A_DATA, 32'h81, 1'b1);
    wait_idle(n);
    sb.push_back(8'h7E);
    wr(A_DATA, 32'h7E, 1'b1);
    wait_idle(n);
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h6) begin failures++; $display("FAIL b2b_second_status got=%h exp=6", v); end
    rdreg(A_DATA, 1'b1, v);
    check_pop("b2b_second_data", v);
    wr(A_STATUS, 32'h4, 1'b1);
  endtask

  task automatic test_rx_valid();
    logic [31:0] v;
    int n;
    sb.push_back(8'hC3);
    wr(A_DATA, 32'hC3, 1'b1);
    wait_idle(n);
    rdreg(A_DATA, 1'b0, v);
    check_pop("rxv_data_noreq", v);
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL rxv_re0_keeps got=%h exp=2", v); end
    rdreg(A_DATA, 1'b1, v);
    rdreg(A_STATUS, 1'b0, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rxv_re1_clears got=%h exp=0", v); end
    wr(A_DATA, 32'hFF, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rd !== 32'h0 || ss_n !== 1'b1) begin
      failures++; $display("FAIL cs0_write status=%h ss_n=%b exp 0/1", rd, ss_n); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int n, base, k;
    sb.push_back(8'h42);
    wr(A_DATA, 32'h42, 1'b1);
    wait_idle(n);
    rdreg(A_DATA, 1'b0, v);
    check_pop("mid_pre_data", v);
    base = rises;
    wr(A_DATA, 32'h77, 1'b1);
    k = 0;
    while (rises - base < 4 && k < 500) begin @(negedge clk); k++; end
    checks++; if (rises - base != 4) begin failures++; $display("FAIL mid_reach_bit3 rises=%0d exp=4", rises - base); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (ss_n !== 1'b1 || sclk !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL mid_abort ss_n=%b sclk=%b status=%h exp 1/0/0", ss_n, sclk, rd); end
    @(negedge clk) reset = 1'b0;
    sb.push_back(8'h5A);
    wr(A_DATA, 32'h5A, 1'b1);
    wait_idle(n);
    checks++; if (n != 86) begin failures++; $display("FAIL mid_after_busy got=%0d exp=86", n); end
    rdreg(A_DATA, 1'b1, v);
    check_pop("mid_after_data", v);
  endtask

  initial begin
    test_reset();
    test_loopback_d0();
    test_miso_high_d3();
    test_back_to_back();
    test_rx_valid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
